// File: rtl/chacha_pkg.sv
// Shared types, quarter-round word groupings and rotate helper for the ChaCha engines.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] state_t;

    // Column round groups (a,b,c,d word indices), one row per quarter round.
    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    // Diagonal round groups.
    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    // Rotate right; n is always a constant in 1..31 at the call sites.
    function automatic word_t rotr32(input word_t v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

endpackage

// File: rtl/chacha_inv_core_iqr.sv
// Combinational inverse ChaCha quarter round: undoes the forward QR on (a,b,c,d).
module inv_quarter_round
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t w,
    output word_t x,
    output word_t y,
    output word_t z
);

    word_t b1, c1, d1, a1, b2, c2, d2;

    // Forward steps are peeled off last-first; each line reuses already-updated words.
    assign b1 = rotr32(b, 7) ^ c;
    assign c1 = c - d;
    assign d1 = rotr32(d, 8) ^ a;
    assign a1 = a - b1;
    assign b2 = rotr32(b1, 12) ^ c1;
    assign c2 = c1 - d1;
    assign d2 = rotr32(d1, 16) ^ a1;

    assign w = a1 - b2;
    assign x = b2;
    assign y = c2;
    assign z = d2;

endmodule

// File: rtl/chacha_inv_core.sv
// Sequential inverse ChaCha permutation: one inverse half-round (4 parallel IQRs) per cycle.
module chacha_inv_core
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [4:0] LAST_HALF = 5'(2 * DOUBLE_ROUNDS - 1);

    fsm_t       fsm, fsm_nxt;
    logic [4:0] half_cnt;
    state_t     work, work_nxt;
    logic [3:0] idx [4][4];
    word_t      qa [4], qb [4], qc [4], qd [4];
    word_t      qw [4], qx [4], qy [4], qz [4];

    // Inverse order is diagonal then column, so even half-rounds use the diagonals.
    always_comb begin
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                idx[g][k] = half_cnt[0] ? COL_IDX[g][k] : DIAG_IDX[g][k];
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        assign qa[g] = work[idx[g][0]];
        assign qb[g] = work[idx[g][1]];
        assign qc[g] = work[idx[g][2]];
        assign qd[g] = work[idx[g][3]];

        inv_quarter_round u_iqr (
            .a(qa[g]), .b(qb[g]), .c(qc[g]), .d(qd[g]),
            .w(qw[g]), .x(qx[g]), .y(qy[g]), .z(qz[g])
        );
    end

    // Scatter the four results back; the groups partition all 16 words.
    always_comb begin
        work_nxt = work;
        for (int g = 0; g < 4; g++) begin
            work_nxt[idx[g][0]] = qw[g];
            work_nxt[idx[g][1]] = qx[g];
            work_nxt[idx[g][2]] = qy[g];
            work_nxt[idx[g][3]] = qz[g];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (half_cnt == LAST_HALF) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Working register and half-round counter; both hold outside IDLE-capture and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            half_cnt <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    work     <= state_in;
                    half_cnt <= '0;
                end
                RUN: begin
                    work     <= work_nxt;
                    half_cnt <= half_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign state_out = work;

endmodule

// File: tb/tb_chacha_inv_core.sv
// Bench: forward-permutation model + round trip through the inverse engine.
module tb_chacha_inv_core;
    import chacha_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [511:0] state_in = '0;
    logic         in_ready, out_valid, busy;
    logic [511:0] state_out;
    logic         v1_in_valid = 1'b0, v1_out_ready = 1'b1;
    logic [511:0] v1_state_in = '0;
    logic         v1_in_ready, v1_out_valid, v1_busy;
    logic [511:0] v1_state_out;
    word_t        qa = '0, qb = '0, qc = '0, qd = '0;
    word_t        qw, qx, qy, qz;

    int checks = 0;
    int failures = 0;
    state_t exp_q[$];

    always #5 clk = ~clk;

    chacha_inv_core #(.DOUBLE_ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );

    chacha_inv_core #(.DOUBLE_ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .state_in(v1_state_in), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .state_out(v1_state_out), .busy(v1_busy)
    );

    inv_quarter_round u_iqr (
        .a(qa), .b(qb), .c(qc), .d(qd), .w(qw), .x(qx), .y(qy), .z(qz)
    );

    // Forward round groups: column round then diagonal round.
    localparam int FWD_GRP [8][4] = '{
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };

    function automatic word_t rotl(input word_t v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic state_t fqr(input state_t s, input int ia, input int ib, input int ic, input int id);
        word_t a, b, c, d;
        a = s[4'(ia)]; b = s[4'(ib)]; c = s[4'(ic)]; d = s[4'(id)];
        a = a + b; d = d ^ a; d = rotl(d, 16);
        c = c + d; b = b ^ c; b = rotl(b, 12);
        a = a + b; d = d ^ a; d = rotl(d, 8);
        c = c + d; b = b ^ c; b = rotl(b, 7);
        s[4'(ia)] = a; s[4'(ib)] = b; s[4'(ic)] = c; s[4'(id)] = d;
        return s;
    endfunction

    function automatic state_t fwd(input state_t s, input int dr);
        for (int r = 0; r < dr; r++)
            for (int g = 0; g < 8; g++)
                s = fqr(s, FWD_GRP[g][0], FWD_GRP[g][1], FWD_GRP[g][2], FWD_GRP[g][3]);
        return s;
    endfunction

    function automatic state_t rnd_state();
        state_t s;
        for (int i = 0; i < 16; i++) s[4'(i)] = $urandom;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Whenever a result is presented it must be the next expected original state.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out_valid got=1 exp=0");
            end else begin
                chk("state_out", state_out, exp_q[0]);
            end
            chk("in_ready_in_done", 512'(in_ready), 512'(0));
            chk("busy_in_done", 512'(busy), 512'(0));
        end
    end

    always @(posedge clk) begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    // Present one block (drive), queue its expected result, return cycles to out_valid.
    task automatic send(input state_t drv, input state_t exp, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        chk("in_ready_wait", 512'(in_ready), 512'(1));
        exp_q.push_back(exp);
        in_valid = 1'b1;
        state_in = drv;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    endtask

    initial begin
        state_t s, t, bp_exp;
        int lat;
        logic seen;

        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s, t;
        int lat;
        logic seen;

        // Reset values.
        #1;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_state_out", state_out, '0);
        chk("rst_v1_in_ready", 512'(v1_in_ready), 512'(1));

        // RFC 7539 quarter-round vector through the inverse QR and through the model.
        qa = 32'hea2a92f4; qb = 32'hcb1cf8ce; qc = 32'h4581472e; qd = 32'h5881c4bb;
        #1;
        chk("iqr_rfc", {qw, qx, qy, qz}, {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567});
        t = '0;
        t[0] = 32'h11111111; t[1] = 32'h01020304; t[2] = 32'h9b8d6f43; t[3] = 32'h01234567;
        t = fqr(t, 0, 1, 2, 3);
        chk("model_fqr_rfc", {t[0], t[1], t[2], t[3]},
            {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb});

        @(negedge clk);
        rst_n = 1'b1;

        // All-zero state is a fixed point of the permutation.
        send('0, '0, lat);
        chk("zero_latency", 512'(lat), 512'(20));
        chk("zero_state", state_out, '0);

        // Round trip of random states.
        for (int n = 0; n < 100; n++) begin
            s = rnd_state();
            send(fwd(s, 10), s, lat);
            chk("rt_latency", 512'(lat), 512'(20));
        end

        // DOUBLE_ROUNDS = 1 variant.
        for (int n = 0; n < 3; n++) begin
            s = rnd_state();
            @(negedge clk);
            v1_in_valid = 1'b1;
            v1_state_in = fwd(s, 1);
            @(negedge clk);
            v1_in_valid = 1'b0;
            lat = 0;
            while (!v1_out_valid && lat < 50) begin @(negedge clk); lat++; end
            chk("dr1_latency", 512'(lat), 512'(2));
            chk("dr1_state", v1_state_out, s);
        end

        // Backpressure with in_valid pulsing while DONE.
        out_ready = 1'b0;
        s = rnd_state();
        send(fwd(s, 10), s, lat);
        chk("bp_latency", 512'(lat), 512'(20));
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            state_in = rnd_state();
            @(negedge clk);
            chk("bp_state_hold", state_out, s);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_out_valid", 512'(out_valid), 512'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_in_ready", 512'(in_ready), 512'(1));
        chk("bp_idle_out_valid", 512'(out_valid), 512'(0));
        chk("bp_idle_busy", 512'(busy), 512'(0));

        // Reset while half_cnt == 9.
        s = rnd_state();
        @(negedge clk);
        exp_q.push_back(s);
        in_valid = 1'b1;
        state_in = fwd(s, 10);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 512'(busy), 512'(1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
        chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_state_out", state_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("post_rst_quiet", 512'(seen), 512'(0));
        s = rnd_state();
        send(fwd(s, 10), s, lat);
        chk("post_rst_latency", 512'(lat), 512'(20));
        chk("post_rst_state", state_out, s);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
